bnn_job_sequencer: RTL and testbench

//  Sequences one BNN inference per image: accepts a flattened image by valid/ready handshake, snapshots
//  it, pulses start into the BNN core, and waits for done with a timeout watchdog. Presents the class

---
 rtl/bnn_job_sequencer.sv | 121 ++++++++++++
 tb/tb_bnn_job_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_job_sequencer.sv
// Job sequencer between the image buffer and the BNN core: accept image, start, watchdog, hold result.
// Optional start-to-done latency counter enabled by defining BNN_SEQ_PERF_EN.
module bnn_job_sequencer #(
  parameter int IMG_W          = 900,
  parameter int RES_W          = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_valid,
  output logic             img_ready,
  input  logic [IMG_W-1:0] img_data,
  output logic [IMG_W-1:0] bnn_img,
  output logic             bnn_start,
  input  logic             bnn_done,
  input  logic [RES_W-1:0] bnn_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] infer_count,
  output logic [CNT_W-1:0] last_latency,
  output logic [1:0]       state_dbg
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [WD_W-1:0] watchdog;
  logic            accept;
  logic            done_hit;
  logic            timeout_hit;

  // Both interfaces: a transfer happens on a rising edge where valid && ready;
  // the source holds data stable while valid && !ready.
  always_comb begin
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    if (state == IDLE) accept = img_valid;
    if (state == RUN) begin
      done_hit    = bnn_done;
      timeout_hit = !bnn_done && (watchdog == WD_LAST);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (done_hit || timeout_hit) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bnn_img     <= '0;
      bnn_start   <= 1'b0;
      watchdog    <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      infer_count <= '0;
    end else begin
      bnn_start <= accept;
      if (accept) bnn_img <= img_data;
      if (state == START)    watchdog <= '0;
      else if (state == RUN) watchdog <= watchdog + WD_W'(1);
      if (done_hit) begin
        res_data    <= bnn_result;
        res_timeout <= 1'b0;
        infer_count <= infer_count + CNT_W'(1);
      end else if (timeout_hit) begin
        res_data    <= '1;
        res_timeout <= 1'b1;
      end
    end
  end

`ifdef BNN_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_cnt;

  // perf_cnt equals cycles elapsed since the bnn_start cycle, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt     <= '0;
      last_latency <= '0;
    end else begin
      if (state == START) perf_cnt <= CNT_W'(1);
      else if (state == RUN && perf_cnt != '1) perf_cnt <= perf_cnt + CNT_W'(1);
      if (done_hit) last_latency <= perf_cnt;
    end
  end
`else
  assign last_latency = '0;
`endif

  assign img_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD);
  assign state_dbg = state;

endmodule

// File: tb/tb_bnn_job_sequencer.sv
// Bench for bnn_job_sequencer: directed jobs, a cycle-level reference model with per-cycle compare,
// and a result scoreboard. Honours BNN_SEQ_PERF_EN for last_latency expectations.
module tb_bnn_job_sequencer;
  localparam int IMG_W   = 900;
  localparam int RES_W   = 4;
  localparam int TO      = 16;
  localparam int CNT_W   = 4;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             img_valid = 1'b0;
  logic             img_ready;
  logic [IMG_W-1:0] img_data = '0;
  logic [IMG_W-1:0] bnn_img;
  logic             bnn_start;
  logic             bnn_done = 1'b0;
  logic [RES_W-1:0] bnn_result = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             busy;
  logic [CNT_W-1:0] infer_count;
  logic [CNT_W-1:0] last_latency;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;
  logic [RES_W:0] exp_q[$];

  bnn_job_sequencer #(
    .IMG_W(IMG_W), .RES_W(RES_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
    .bnn_img(bnn_img), .bnn_start(bnn_start),
    .bnn_done(bnn_done), .bnn_result(bnn_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy),
    .infer_count(infer_count), .last_latency(last_latency),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Job timeline: accept edge, one start cycle, run cycles counted from 0, result held until taken.
  logic             in_job, m_start, have_res, m_to;
  int               run_cycles;
  logic [IMG_W-1:0] m_img;
  logic [RES_W-1:0] m_data;
  logic [CNT_W-1:0] m_cnt, m_lat;

  always @(posedge clk) begin
    if (rst) begin
      in_job = 0; m_start = 0; have_res = 0; m_to = 0; run_cycles = 0;
      m_img = '0; m_data = '0; m_cnt = '0; m_lat = '0;
    end else if (!in_job) begin
      if (img_valid) begin
        in_job = 1; m_start = 1; m_img = img_data;
      end
    end else if (m_start) begin
      m_start = 0; run_cycles = 0;
    end else if (!have_res) begin
      if (bnn_done) begin
        have_res = 1; m_data = bnn_result; m_to = 0; m_cnt = m_cnt + 1'b1;
`ifdef BNN_SEQ_PERF_EN
        m_lat = (run_cycles + 1 > LAT_MAX) ? CNT_W'(LAT_MAX) : CNT_W'(run_cycles + 1);
`endif
      end else if (run_cycles == TO - 1) begin
        have_res = 1; m_data = '1; m_to = 1;
      end else begin
        run_cycles++;
      end
    end else if (res_ready) begin
      have_res = 0; in_job = 0;
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("img_ready", img_ready, !in_job);
      chk("busy", busy, in_job);
      chk("bnn_start", bnn_start, m_start);
      chk("res_valid", res_valid, have_res);
      chk("res_data", res_data, m_data);
      chk("res_timeout", res_timeout, m_to);
      chk("infer_count", infer_count, m_cnt);
      chk("last_latency", last_latency, m_lat);
      chk_img("bnn_img", bnn_img, m_img);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_result", 1, 0);
        else chk("sb_result", {res_timeout, res_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [IMG_W-1:0] img, input int done_at,
                           input logic [RES_W-1:0] result, output int run_len,
                           output logic [RES_W-1:0] got_data, output logic got_to);
    int guard = 0;
    int n = 0;
    img_valid = 1'b1;
    img_data  = img;
    while (!img_ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("accept_wait", img_ready, 1);
    tick();
    img_valid = 1'b0;
    chk("start_pulse", bnn_start, 1);
    tick();
    while (!res_valid && n < TO + 4) begin
      if (n == done_at) begin
        bnn_done   = 1'b1;
        bnn_result = result;
      end
      tick();
      bnn_done = 1'b0;
      n++;
    end
    chk("res_wait", res_valid, 1);
    run_len  = n;
    got_data = res_data;
    got_to   = res_timeout;
  endtask

  task automatic finish_job(input int hold);
    res_ready = 1'b0;
    repeat (hold) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [IMG_W-1:0] pat_a, pat_b, pat_c, pat_r;
  int               rl;
  logic [RES_W-1:0] gd;
  logic             gt;
  logic [CNT_W-1:0] lat_exp;

  initial begin
    for (int i = 0; i < IMG_W; i++) begin
      pat_a[i] = (i % 3 == 0);
      pat_b[i] = 1'($urandom_range(0, 1));
      pat_c[i] = (i % 7 == 2) || (i > 800);
    end

    tick();
    cmp_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_img_ready", img_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_infer_count", infer_count, 0);
    chk_img("reset_bnn_img", bnn_img, '0);

    // 1: good job, done on the 10th run cycle
    exp_q.push_back({1'b0, 4'd7});
    start_job(pat_a, 9, 4'd7, rl, gd, gt);
    chk("t1_run_len", rl, 10);
    chk("t1_res_data", gd, 7);
    chk("t1_timeout", gt, 0);
    chk("t1_infer_count", infer_count, 1);
`ifdef BNN_SEQ_PERF_EN
    lat_exp = 4'd10;
`else
    lat_exp = 4'd0;
`endif
    chk("t1_latency", last_latency, lat_exp);
    finish_job(0);

    // 2: watchdog abort
    exp_q.push_back({1'b1, 4'hF});
    start_job(pat_c, -1, 4'd0, rl, gd, gt);
    chk("t2_run_len", rl, 16);
    chk("t2_res_data", gd, 4'hF);
    chk("t2_timeout", gt, 1);
    chk("t2_infer_count", infer_count, 1);
    chk("t2_latency_kept", last_latency, lat_exp);
    finish_job(3);

    // 3: done on the last watchdog cycle wins over timeout; latency 16 saturates at 15
    exp_q.push_back({1'b0, 4'd3});
    start_job(pat_b, 15, 4'd3, rl, gd, gt);
    chk("t3_run_len", rl, 16);
    chk("t3_res_data", gd, 3);
    chk("t3_timeout", gt, 0);
    chk("t3_infer_count", infer_count, 2);
`ifdef BNN_SEQ_PERF_EN
    chk("t3_latency_sat", last_latency, 15);
`else
    chk("t3_latency_off", last_latency, 0);
`endif
    finish_job(1);

    // 4: consumer stalls 20 cycles while image B waits; stray done ignored
    exp_q.push_back({1'b0, 4'd5});
    start_job(pat_a, 2, 4'd5, rl, gd, gt);
    img_valid = 1'b1;
    img_data  = pat_b;
    for (int k = 0; k < 20; k++) begin
      chk("t4_res_valid", res_valid, 1);
      chk("t4_res_data", res_data, 5);
      chk("t4_img_ready", img_ready, 0);
      chk_img("t4_bnn_img_a", bnn_img, pat_a);
      if (k == 5) begin
        bnn_done   = 1'b1;
        bnn_result = 4'd9;
      end
      tick();
      bnn_done = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4_ready_after_hs", img_ready, 1);
    chk_img("t4_bnn_img_still_a", bnn_img, pat_a);
    exp_q.push_back({1'b0, 4'd6});
    start_job(pat_b, 0, 4'd6, rl, gd, gt);
    chk_img("t4_bnn_img_b", bnn_img, pat_b);
    chk("t4_infer_count", infer_count, 4);
    finish_job(0);

    // 5: reset in the middle of a run, then a late done
    img_valid = 1'b1;
    img_data  = pat_c;
    tick();
    img_valid = 1'b0;
    repeat (4) tick();
    chk("t5_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    bnn_done   = 1'b1;
    bnn_result = 4'd2;
    repeat (3) tick();
    bnn_done = 1'b0;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_infer_count", infer_count, 0);
    chk("t5_busy", busy, 0);
    chk_img("t5_bnn_img", bnn_img, '0);
    chk("t5_res_data", res_data, 0);
    chk("t5_last_latency", last_latency, 0);

    // counter wrap: 17 good jobs on a 4-bit counter
    for (int j = 0; j < 17; j++) begin
      for (int i = 0; i < IMG_W; i++) pat_r[i] = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, 4'(j)});
      start_job(pat_r, int'($urandom_range(0, 4)), 4'(j), rl, gd, gt);
      finish_job(int'($urandom_range(0, 3)));
    end
    chk("wrap_infer_count", infer_count, 1);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
